// File: rtl/dab_bridge_gate_driver.sv
// dab_bridge_gate_driver: H-bridge gate driver with per-leg dead time and illegal-command shutdown.
// Define DAB_FAULT_LATCH_EN to make fault sticky (legs held OFF until rst).
module dab_bridge_gate_driver #(
  parameter int DT_CYCLES = 10,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] v_cmd,
  output logic       g_a_hi,
  output logic       g_a_lo,
  output logic       g_b_hi,
  output logic       g_b_lo,
  output logic       busy,
  output logic       fault
);
  typedef enum logic [1:0] {OFF, DEAD, HI_ON, LO_ON} state_t;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(DT_CYCLES - 1);
  state_t           st [2];
  state_t           nx [2];
  logic [CNT_W-1:0] cnt [2];
  logic [CNT_W-1:0] cnt_nx [2];
  logic [1:0]       tgt;
  logic             ill, off, fault_nx;
  assign ill = v_cmd == 2'b10;
  // Leg A targets high-side on +Vdc, leg B on -Vdc; otherwise low-side.
  assign tgt = {v_cmd == 2'b11, v_cmd == 2'b01};
`ifdef DAB_FAULT_LATCH_EN
  assign off      = !en || ill || fault;
  assign fault_nx = fault || ill;
`else
  assign off      = !en || ill;
  assign fault_nx = ill;
`endif
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      nx[i]     = st[i];
      cnt_nx[i] = cnt[i];
      if (off) begin
        nx[i]     = OFF;
        cnt_nx[i] = '0;
      end else if (st[i] == OFF || (st[i] == HI_ON && !tgt[i]) || (st[i] == LO_ON && tgt[i])) begin
        nx[i]     = DEAD;
        cnt_nx[i] = LOAD;
      end else if (st[i] == DEAD) begin
        if (cnt[i] == '0) nx[i] = tgt[i] ? HI_ON : LO_ON;
        else cnt_nx[i] = cnt[i] - 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st[0]  <= OFF;
      st[1]  <= OFF;
      cnt[0] <= '0;
      cnt[1] <= '0;
      g_a_hi <= 1'b0;
      g_a_lo <= 1'b0;
      g_b_hi <= 1'b0;
      g_b_lo <= 1'b0;
      busy   <= 1'b0;
      fault  <= 1'b0;
    end else begin
      st[0]  <= nx[0];
      st[1]  <= nx[1];
      cnt[0] <= cnt_nx[0];
      cnt[1] <= cnt_nx[1];
      g_a_hi <= nx[0] == HI_ON;
      g_a_lo <= nx[0] == LO_ON;
      g_b_hi <= nx[1] == HI_ON;
      g_b_lo <= nx[1] == LO_ON;
      busy   <= nx[0] == DEAD || nx[1] == DEAD;
      fault  <= fault_nx;
    end
  end
endmodule

// File: tb/tb_dab_bridge_gate_driver.sv
// tb_dab_bridge_gate_driver: directed and randomized checks against a time-based reference model.
module tb_dab_bridge_gate_driver;
  localparam int DT = 10;
  logic       clk = 1'b0;
  logic       rst, en;
  logic [1:0] v_cmd;
  logic       g_a_hi, g_a_lo, g_b_hi, g_b_lo, busy, fault;
  int         pass_cnt = 0, tot_cnt = 0;
  bit         cmp_on = 0;
  wire  [5:0] outs = {g_a_hi, g_a_lo, g_b_hi, g_b_lo, busy, fault};

  dab_bridge_gate_driver #(.DT_CYCLES(DT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .v_cmd(v_cmd),
    .g_a_hi(g_a_hi), .g_a_lo(g_a_lo), .g_b_hi(g_b_hi), .g_b_lo(g_b_lo),
    .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    tot_cnt++;
    if (act !== exp) $display("FAIL %s got %b expected %b at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Reference: each leg is off, dead until an absolute edge index, or conducting one side.
  int cyc = 0;
  int mode [2] = '{0, 0};
  int dend [2] = '{0, 0};
  bit on_hi [2] = '{0, 0};
  bit m_fault = 0;
  always @(posedge clk) begin
    bit ill, offc;
    bit t [2];
    cyc++;
    ill  = v_cmd == 2'b10;
    t[0] = v_cmd == 2'b01;
    t[1] = v_cmd == 2'b11;
`ifdef DAB_FAULT_LATCH_EN
    offc = !en || ill || m_fault;
    m_fault = rst ? 1'b0 : (m_fault || ill);
`else
    offc = !en || ill;
    m_fault = rst ? 1'b0 : ill;
`endif
    for (int i = 0; i < 2; i++) begin
      if (rst || offc) mode[i] = 0;
      else if (mode[i] == 0) begin mode[i] = 1; dend[i] = cyc + DT; end
      else if (mode[i] == 1 && cyc == dend[i]) begin mode[i] = 2; on_hi[i] = t[i]; end
      else if (mode[i] == 2 && t[i] != on_hi[i]) begin mode[i] = 1; dend[i] = cyc + DT; end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model", outs, {mode[0] == 2 && on_hi[0], mode[0] == 2 && !on_hi[0],
                          mode[1] == 2 && on_hi[1], mode[1] == 2 && !on_hi[1],
                          mode[0] == 1 || mode[1] == 1, m_fault});
      chk("excl", {4'b0, g_a_hi & g_a_lo, g_b_hi & g_b_lo}, 6'b0);
    end
  end

  initial begin
    rst = 1; en = 0; v_cmd = 2'b00;
    @(negedge clk);
    cmp_on = 1;
    repeat (2) @(negedge clk);
    chk("reset", outs, 6'b000000);
    rst = 0; en = 1; v_cmd = 2'b01;
    @(negedge clk);            chk("pos_dead_first", outs, 6'b000010);
    repeat (9) @(negedge clk); chk("pos_dead_last", outs, 6'b000010);
    @(negedge clk);            chk("pos_on", outs, 6'b100100);
    v_cmd = 2'b00;
    @(negedge clk);            chk("zero_b_kept", outs, 6'b000110);
    repeat (3) @(negedge clk);
    v_cmd = 2'b01;
    repeat (6) @(negedge clk); chk("ret_full_dead", outs, 6'b000110);
    @(negedge clk);            chk("ret_hi", outs, 6'b100100);
    v_cmd = 2'b11;
    @(negedge clk);            chk("neg_dead_first", outs, 6'b000010);
    repeat (9) @(negedge clk); chk("neg_dead_last", outs, 6'b000010);
    @(negedge clk);            chk("neg_on", outs, 6'b011000);
    v_cmd = 2'b10;
    @(negedge clk);            chk("fault_set", outs, 6'b000001);
    v_cmd = 2'b01;
`ifdef DAB_FAULT_LATCH_EN
    @(negedge clk);            chk("fault_held", outs, 6'b000001);
    repeat (10) @(negedge clk); chk("fault_still", outs, 6'b000001);
`else
    @(negedge clk);            chk("fault_clear", outs, 6'b000010);
    repeat (10) @(negedge clk); chk("fault_recover", outs, 6'b100100);
`endif
    rst = 1;
    @(negedge clk);            chk("rst_mid", outs, 6'b000000);
    rst = 0;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      rst = ($urandom % 600) == 0;
      en  = ($urandom % 80) != 0;
      if (($urandom % 12) == 0) begin
        v_cmd = 2'($urandom);
        if (v_cmd == 2'b10 && ($urandom % 4) != 0) v_cmd = 2'b01;
      end
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
